mvu_drain: RTL and testbench
============================

Name: mvu_drain

Overview:
- Output-side reader for the matrix-vector unit; consumes the n parallel accumulator lanes and emits them one lane per beat on a valid/ready stream.
- On `start`, snapshots the full accumulator vector, so the accumulators may be cleared and reused immediately.
- Drains the snapshot lane 0 first through lane n-1.
- Each lane is arithmetic-right-shifted by a per-drain amount and saturated to a narrower signed output word for the next layer or host.

Parameters:
- n, 64, number of accumulator lanes (matches the MVU lane count).
- w, 32, accumulator lane width in bits (signed two's complement).
- q, 16, output word width in bits (signed); 2 <= q <= w.

Ports:
- clk    input   1               rising-edge clock.
- clr_n  input   1               synchronous active-low reset, sampled on rising edge of clk.
- start  input   1               request to snapshot O and begin a drain.
- shamt  input   $clog2(w)       arithmetic right-shift amount; captured with the snapshot.
- O      input   n*w             accumulator lanes; lane i is at bits [i*w +: w].
- busy   output  1               high while a drain is in progress.
- ovalid output  1               output beat valid.
- oready input   1               downstream ready.
- odata  output  q               shifted, saturated lane value.
- olast  output  1               high with the beat carrying lane n-1.
- osat   output  1               high when the current beat's value was saturated.
- done   output  1               one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset: clr_n low at a rising edge forces IDLE. busy=0, ovalid=0, olast=0, osat=0, done=0, odata=0. Lane index and snapshot register are don't-care. Reset mid-drain abandons the drain; no done pulse is issued.
- States:
  - IDLE: busy=0, ovalid=0.
  - SEND: busy=1, ovalid=1.
- Start acceptance:
  - start is accepted in IDLE.
  - start is also accepted in SEND on the same cycle the lane n-1 beat handshakes (ovalid & oready & olast). This allows back-to-back drains with no bubble.
  - start at any other time in SEND is ignored; no queueing.
- On acceptance at edge t:
  - snapshot <= O; shamt_r <= shamt; lane <= 0; state <= SEND.
  - Lane 0 is presented with ovalid=1 after edge t (latency 1 cycle).
- Handshake:
  - A beat transfers on a rising edge where ovalid & oready.
  - While ovalid & !oready, odata, olast and osat hold stable.
  - On transfer of a non-last beat, lane increments and the next lane appears the following cycle.
  - Throughput is 1 lane/cycle with oready held high.
- Completion:
  - When lane n-1 transfers and no start is accepted that cycle, the state returns to IDLE.
  - done pulses high for exactly one cycle after the final handshake edge, in both the IDLE and back-to-back cases.
- Arithmetic, per beat, on v = snapshot lane (signed w):
  - s = v >>> shamt_r (arithmetic shift; truncation toward -infinity).
  - If s > 2^(q-1)-1: odata = 2^(q-1)-1, osat=1.
  - If s < -2^(q-1): odata = -2^(q-1), osat=1.
  - Otherwise odata = s[q-1:0], osat=0.
  - shamt_r=0 is a valid pass-through with saturation.
  - odata/osat may be combinational from the registered snapshot/lane, or registered, but must meet the stability rule and the 1-cycle latency.
- Sampling: O is sampled only at the acceptance edge. Changes to O during SEND have no effect.
- n=1: the single beat carries olast=1.

Test Plan (n=4, w=32, q=16 unless stated):
1. Reset pulse, then idle with start=0 → busy=0, ovalid=0, done=0 throughout.
2. Basic drain:
   - Stimulus: O lanes {100, -100, 40000, -40000}, shamt=0, start 1 cycle, oready=1.
   - Response: ovalid 1 cycle later; odata 100, -100, 32767 (osat=1), -32768 (osat=1) on consecutive cycles; olast on beat 4; done 1 cycle after; busy=0.
3. Shift and rounding:
   - Stimulus: lanes {0x00010000, -3, 7, -1}, shamt=4.
   - Response: odata 4096, -1, 0, -1, all with osat=0.
4. Backpressure:
   - Stimulus: oready toggled 1,0,0,1,0,1,... and O changed after start.
   - Response: odata/olast stable while stalled; all 4 original values delivered in order; no duplicates or drops.
5. Start handling:
   - Start pulsed mid-drain → ignored; drain unaffected.
   - Start asserted on the lane-3 handshake cycle with new O {1,2,3,4} → lane 0 of the new drain (odata=1) appears the next cycle with no bubble; done pulses once for the first drain.
6. Reset mid-drain:
   - Stimulus: clr_n low after beat 2.
   - Response: next cycle ovalid=0, busy=0, done=0; a subsequent start drains correctly from lane 0.

Source files
------------

// File: rtl/mvu_drain.sv
// mvu_drain: snapshots accumulator lanes on start and streams them out one per beat, shifted and saturated.
module mvu_drain #(
  parameter int n = 64,
  parameter int w = 32,
  parameter int q = 16
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 start,
  input  logic [$clog2(w)-1:0] shamt,
  input  logic [n*w-1:0]       O,
  output logic                 busy,
  output logic                 ovalid,
  input  logic                 oready,
  output logic [q-1:0]         odata,
  output logic                 olast,
  output logic                 osat,
  output logic                 done
);
  localparam int LW = n > 1 ? $clog2(n) : 1;
  localparam logic signed [w-1:0] MAXV = {{(w-q+1){1'b0}}, {(q-1){1'b1}}};
  localparam logic signed [w-1:0] MINV = ~MAXV;
  typedef enum logic {IDLE, SEND} state_t;
  state_t              state_q, state_d;
  logic [LW-1:0]       lane_q, lane_d;
  logic [n*w-1:0]      snap_q, snap_d;
  logic [$clog2(w)-1:0] sh_q, sh_d;
  logic                done_q, done_d;
  logic                fire, last, acc, sat_hi, sat_lo;
  logic signed [w-1:0] v, s;
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end
  // Lane index and snapshot need no reset: they are only observed in SEND.
  always_ff @(posedge clk) begin
    lane_q <= lane_d;
    snap_q <= snap_d;
    sh_q   <= sh_d;
  end
  always_comb begin
    ovalid  = state_q == SEND;
    busy    = ovalid;
    last    = lane_q == LW'(n - 1);
    fire    = ovalid & oready;
    acc     = start & (!ovalid | (fire & last));
    state_d = acc ? SEND : (fire & last) ? IDLE : state_q;
    lane_d  = acc ? '0 : fire ? lane_q + 1'b1 : lane_q;
    snap_d  = acc ? O : snap_q;
    sh_d    = acc ? shamt : sh_q;
    done_d  = fire & last;
    v       = snap_q[lane_q*w +: w];
    s       = v >>> sh_q;
    sat_hi  = s > MAXV;
    sat_lo  = s < MINV;
    olast   = ovalid & last;
    osat    = ovalid & (sat_hi | sat_lo);
    odata   = !ovalid ? '0 : sat_hi ? MAXV[q-1:0] : sat_lo ? MINV[q-1:0] : s[q-1:0];
  end
  assign done = done_q;
endmodule

// File: tb/tb_mvu_drain.sv
// tb_mvu_drain: directed checks of the drain stream for n=4, w=32, q=16.
module tb_mvu_drain;
  logic         clk = 1'b0, clr_n = 1'b0, start = 1'b0, oready = 1'b0;
  logic [4:0]   shamt = '0;
  logic [127:0] O = '0;
  logic         busy, ovalid, olast, osat, done;
  logic [15:0]  odata;
  int           checks = 0, failures = 0;

  mvu_drain #(.n(4), .w(32), .q(16)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .shamt(shamt), .O(O),
    .busy(busy), .ovalid(ovalid), .oready(oready), .odata(odata),
    .olast(olast), .osat(osat), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_o(input int a, input int b, input int c, input int d);
    O = {d, c, b, a};
  endtask

  task automatic beat(input string tag, input int d, input bit sat, input bit lst);
    chk({tag, "_valid"}, 32'(ovalid), 1);
    chk({tag, "_data"}, $signed(odata), d);
    chk({tag, "_sat"}, 32'(osat), 32'(sat));
    chk({tag, "_last"}, 32'(olast), 32'(lst));
    step();
  endtask

  task automatic go(input int a, input int b, input int c, input int d, input logic [4:0] sh);
    set_o(a, b, c, d);
    shamt = sh;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  logic [15:0] pat = 16'b1010_0101_0010_1001;
  int exp_bp[4] = '{10, 20, 30, 40};

  initial begin
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(ovalid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_data", $signed(odata), 0);
    chk("rst_last", 32'(olast), 0);
    chk("rst_sat", 32'(osat), 0);
    clr_n = 1'b1;
    oready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_busy", 32'(busy), 0);
      chk("idle_valid", 32'(ovalid), 0);
      chk("idle_done", 32'(done), 0);
    end
    // basic drain with saturation
    go(100, -100, 40000, -40000, 5'd0);
    chk("b_busy", 32'(busy), 1);
    chk("b_done0", 32'(done), 0);
    beat("b0", 100, 0, 0);
    beat("b1", -100, 0, 0);
    beat("b2", 32767, 1, 0);
    beat("b3", -32768, 1, 1);
    chk("b_done", 32'(done), 1);
    chk("b_idle_valid", 32'(ovalid), 0);
    chk("b_idle_busy", 32'(busy), 0);
    step();
    chk("b_done_once", 32'(done), 0);
    // shift with truncation toward -infinity
    go(32'h0001_0000, -3, 7, -1, 5'd4);
    beat("s0", 4096, 0, 0);
    beat("s1", -1, 0, 0);
    beat("s2", 0, 0, 0);
    beat("s3", -1, 0, 1);
    chk("s_done", 32'(done), 1);
    step();
    // backpressure, with O changed after acceptance
    go(10, 20, 30, 40, 5'd0);
    set_o(-7, -7, -7, -7);
    begin
      int k = 0;
      for (int c = 0; c < 16 && k < 4; c++) begin
        oready = pat[c];
        chk("bp_valid", 32'(ovalid), 1);
        chk("bp_data", $signed(odata), exp_bp[k]);
        chk("bp_last", 32'(olast), 32'(k == 3));
        step();
        if (pat[c]) k++;
      end
      chk("bp_count", k, 4);
    end
    chk("bp_done", 32'(done), 1);
    oready = 1'b1;
    step();
    // ignored mid-drain start, then back-to-back start on the last handshake
    go(5, 6, 7, 8, 5'd0);
    beat("m0", 5, 0, 0);
    set_o(9, 9, 9, 9);
    start = 1'b1;
    beat("m1", 6, 0, 0);
    start = 1'b0;
    beat("m2", 7, 0, 0);
    set_o(1, 2, 3, 4);
    start = 1'b1;
    beat("m3", 8, 0, 1);
    start = 1'b0;
    chk("bb_done", 32'(done), 1);
    chk("bb_busy", 32'(busy), 1);
    beat("bb0", 1, 0, 0);
    chk("bb_done_once", 32'(done), 0);
    beat("bb1", 2, 0, 0);
    beat("bb2", 3, 0, 0);
    beat("bb3", 4, 0, 1);
    chk("bb_done2", 32'(done), 1);
    step();
    // reset mid-drain
    go(11, 12, 13, 14, 5'd0);
    beat("r0", 11, 0, 0);
    beat("r1", 12, 0, 0);
    clr_n = 1'b0;
    step();
    chk("r_valid", 32'(ovalid), 0);
    chk("r_busy", 32'(busy), 0);
    chk("r_done", 32'(done), 0);
    clr_n = 1'b1;
    step();
    chk("r_done_after", 32'(done), 0);
    go(21, 22, 23, 24, 5'd1);
    beat("a0", 10, 0, 0);
    beat("a1", 11, 0, 0);
    beat("a2", 11, 0, 0);
    beat("a3", 12, 0, 1);
    chk("a_done", 32'(done), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
